// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 theta datapath.
package sha3_pkg;

  localparam int LANE_W        = 64;
  localparam int LANES_PER_ROW = 5;
  localparam int ROWS          = 5;
  localparam int ROW_W         = LANE_W * LANES_PER_ROW;

  typedef logic [LANE_W-1:0] lane_t;

  // Lane x of a row lives in bits [64*x +: 64].
  typedef lane_t [LANES_PER_ROW-1:0] row_t;

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    EVAL   = 2'd1,
    EMIT   = 2'd2
  } theta_seq_state_t;

  // Rotate a lane left by n bit positions (n in 1..63).
  function automatic lane_t rol64(input lane_t v, input int unsigned n);
    return (v << n) | (v >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/sha3_theta_elt_evaluator.sv
// Theta element evaluator: elt[x] = term[x-1] ^ rol(term[x+1], 1),
// indices mod 5, delivered through LATENCY register stages.
module sha3_theta_elt_evaluator
  import sha3_pkg::*;
#(
  parameter string STYLE   = "basic",
  parameter int    LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             term_vld,
  input  logic [ROW_W-1:0] term,
  output logic             elt_vld,
  output logic [ROW_W-1:0] elt
);

  row_t term_lanes;
  row_t elt_comb;

  assign term_lanes = term;

  genvar x;
  for (x = 0; x < LANES_PER_ROW; x++) begin : g_lane
    localparam int XL = (x + LANES_PER_ROW - 1) % LANES_PER_ROW;
    localparam int XR = (x + 1) % LANES_PER_ROW;
    if (STYLE == "basic") begin : g_basic
      assign elt_comb[x] = term_lanes[XL] ^ rol64(term_lanes[XR], 1);
    end else begin : g_concat
      // Same function written as an explicit bit rewire of the rotation.
      assign elt_comb[x] = term_lanes[XL] ^
                           {term_lanes[XR][LANE_W-2:0], term_lanes[XR][LANE_W-1]};
    end
  end

  genvar s;
  for (s = 0; s < LATENCY; s++) begin : g_stage
    row_t elt_d;
    row_t elt_p;
    logic vld_d;
    logic vld_p;

    if (s == 0) begin : g_src
      assign elt_d = elt_comb;
      assign vld_d = term_vld;
    end else begin : g_chain
      assign elt_d = g_stage[s-1].elt_p;
      assign vld_d = g_stage[s-1].vld_p;
    end

    // ---- stage s data register ----
    always_ff @(posedge clk) begin
      elt_p <= elt_d;
    end

    // Valid flag travelling alongside the stage data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p <= 1'b0;
      else      vld_p <= vld_d;
    end
  end

  assign elt     = g_stage[LATENCY-1].elt_p;
  assign elt_vld = g_stage[LATENCY-1].vld_p;

endmodule

// File: rtl/sha3_theta_sequencer.sv
// Keccak theta sequencer: absorbs a 5x5 state one row per beat while
// accumulating column parities, lets the element evaluator settle on the
// frozen parities, then streams out row ^ elt for y = 0..4.
module sha3_theta_sequencer
  import sha3_pkg::*;
#(
  parameter string ELT_STYLE   = "basic",
  parameter int    ELT_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             busy
);

  localparam int CNT_W = $clog2(ELT_LATENCY + 1);

  theta_seq_state_t state;
  theta_seq_state_t state_nxt;

  logic [2:0]       row_cnt;
  logic [CNT_W-1:0] lat_cnt;
  row_t             parity;
  row_t             row_buf [ROWS];

  row_t             in_lanes;
  logic [ROW_W-1:0] elt;
  row_t             elt_lanes;
  logic             elt_vld;
  logic             in_fire;
  logic             out_fire;
  logic             last_row;
  logic             eval_done;

  assign in_lanes  = in_row;
  assign elt_lanes = elt;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_row  = (row_cnt == 3'(ROWS - 1));

  // The evaluator needs LATENCY edges to capture the final parities, and one
  // more edge moves the FSM into EMIT, so the counter runs to ELT_LATENCY.
  assign eval_done = (lat_cnt == CNT_W'(ELT_LATENCY)) && elt_vld;

  sha3_theta_elt_evaluator #(
    .STYLE   (ELT_STYLE),
    .LATENCY (ELT_LATENCY)
  ) u_elt (
    .clk      (clk),
    .rst      (rst),
    .term_vld (state == EVAL),
    .term     (parity),
    .elt_vld  (elt_vld),
    .elt      (elt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ABSORB;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; out_valid comes from state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ABSORB: begin
        in_ready = rst;
        busy     = (row_cnt != 3'd0);
        if (in_valid && last_row) state_nxt = EVAL;
      end
      EVAL: begin
        if (eval_done) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_row) state_nxt = ABSORB;
      end
      default: begin
        state_nxt = ABSORB;
        busy      = 1'b0;
      end
    endcase
  end

  // Row counter, latency counter and parity accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt <= 3'd0;
      lat_cnt <= '0;
      parity  <= '0;
    end else begin
      case (state)
        ABSORB: begin
          if (in_fire) begin
            parity <= parity ^ in_lanes;
            if (last_row) begin
              row_cnt <= 3'd0;
              lat_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        EVAL: begin
          if (lat_cnt != CNT_W'(ELT_LATENCY)) lat_cnt <= lat_cnt + CNT_W'(1);
        end
        EMIT: begin
          if (out_fire) begin
            if (last_row) begin
              row_cnt <= 3'd0;
              parity  <= '0;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        default: begin
          row_cnt <= 3'd0;
          lat_cnt <= '0;
        end
      endcase
    end
  end

  // Row buffer: holds the absorbed state until it has been streamed out.
  always_ff @(posedge clk) begin
    if (in_fire) row_buf[row_cnt] <= in_lanes;
  end

  // Parities are frozen through EMIT, so elt and the selected row stay put
  // during a downstream stall.
  assign out_row = row_buf[row_cnt] ^ elt_lanes;

endmodule
